run_ctrl: RTL and testbench

- Synthesisable run controller for the single-cycle/pipelined mips cores.
- Replaces the fixed delay-then-pulse reset stimulus with a parametrised sequencer. It waits INIT_CYCLES, then drives a core reset pulse of RST_CYCLES to N_CORES cores.
- During the run it counts cycles, latches per-core halt, and ends in DONE when all cores halt or in TIMEOUT at MAX_CYCLES. Supports restart without a global reset.

---
 rtl/run_ctrl.sv | 170 +++++++++++++++++
 tb/tb_run_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: start-up sequencer for the mips cores (WAIT -> core reset pulse -> RUN -> DONE/TIMEOUT).
// Define RUN_CTRL_PC_STALL_EN to add the pc port and treat a stuck PC as a halt request.
module run_ctrl #(
    parameter int N_CORES      = 1,
    parameter int INIT_CYCLES  = 50,
    parameter int RST_CYCLES   = 1,
    parameter int MAX_CYCLES   = 1000,
    parameter int CNT_W        = 16,
    parameter int STALL_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CORES-1:0]      halt,
    input  logic                    restart,
`ifdef RUN_CTRL_PC_STALL_EN
    input  logic [N_CORES*32-1:0]   pc,
`endif
    output logic [N_CORES-1:0]      core_reset,
    output logic                    running,
    output logic                    done,
    output logic                    timeout,
    output logic [N_CORES-1:0]      halted,
    output logic [CNT_W-1:0]        cycle_count
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_RST,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_CYCLES - 1);

    if (INIT_CYCLES < 0 || RST_CYCLES < 1 || MAX_CYCLES < 1 || STALL_CYCLES < 1) begin : g_param_check
        $error("run_ctrl: RST_CYCLES, MAX_CYCLES and STALL_CYCLES must be >= 1, INIT_CYCLES >= 0");
    end

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_CORES-1:0]  r_core_reset;
    logic                r_running;
    logic                r_done;
    logic                r_timeout;
    logic [N_CORES-1:0]  r_halted;
    logic [CNT_W-1:0]    r_cycle_count;

    logic [N_CORES-1:0]  w_halt_eff;
    logic [N_CORES-1:0]  w_halted_next;

`ifdef RUN_CTRL_PC_STALL_EN
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_CYCLES);

    logic [N_CORES*32-1:0] r_prev_pc;
    logic [N_CORES-1:0]    w_stall;

    // NOTE: r_prev_pc is pure data compared only while in RUN, which is always preceded by RST,
    // so it needs no reset; only the control counters are reset.
    always_ff @(posedge clk) begin
        r_prev_pc <= pc;
    end

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_stall
        logic [CNT_W-1:0] r_stall_cnt;

        assign w_stall[gi] = (r_stall_cnt >= STALL_LIM);

        // Saturating count of consecutive RUN cycles with an unchanged PC.
        always_ff @(posedge clk) begin
            if (!reset || r_state != S_RUN) begin
                r_stall_cnt <= '0;
            end else if (pc[32*gi +: 32] != r_prev_pc[32*gi +: 32]) begin
                r_stall_cnt <= '0;
            end else if (!w_stall[gi]) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign w_halt_eff = halt | w_stall;
`else
    assign w_halt_eff = halt;
`endif

    assign w_halted_next = r_halted | w_halt_eff;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_halted      <= '0;
            r_cycle_count <= '0;
            if (INIT_CYCLES == 0) begin
                r_state      <= S_RST;
                r_core_reset <= '1;
            end else begin
                r_state      <= S_WAIT;
                r_core_reset <= '0;
            end
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == INIT_LAST) begin
                        r_state      <= S_RST;
                        r_cnt        <= '0;
                        r_core_reset <= '1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RST: begin
                    r_halted      <= '0;
                    r_cycle_count <= '0;
                    if (r_cnt == RST_LAST) begin
                        r_state      <= S_RUN;
                        r_cnt        <= '0;
                        r_core_reset <= '0;
                        r_running    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    r_halted      <= w_halted_next;
                    r_cycle_count <= r_cycle_count + CNT_W'(1);
                    // A full halt on the last budget cycle still ends in DONE.
                    if (&w_halted_next) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (r_cycle_count == RUN_LAST) begin
                        r_state   <= S_TIMEOUT;
                        r_running <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                S_DONE, S_TIMEOUT: begin
                    if (restart) begin
                        r_state       <= S_RST;
                        r_cnt         <= '0;
                        r_core_reset  <= '1;
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_halted      <= '0;
                        r_cycle_count <= '0;
                    end
                end
                default: begin
                    r_state      <= S_WAIT;
                    r_cnt        <= '0;
                    r_core_reset <= '0;
                    r_running    <= 1'b0;
                end
            endcase
        end
    end

    assign core_reset  = r_core_reset;
    assign running     = r_running;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign halted      = r_halted;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: two run_ctrl instances (default timing, and INIT_CYCLES=0) checked every cycle
// against a timeline model, with directed scenarios followed by randomized halt/restart/reset traffic.
module tb_run_ctrl;

    localparam int A_INIT = 50;
    localparam int A_RST  = 1;
    localparam int A_MAX  = 1000;
    localparam int B_INIT = 0;
    localparam int B_RST  = 3;
    localparam int B_MAX  = 40;
    localparam int STALL  = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [1:0] halt    = 2'b00;
    logic       restart = 1'b0;
    bit         chk_en  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

`ifdef RUN_CTRL_PC_STALL_EN
    logic [63:0] pc      = {32'h0000_2000, 32'h0000_1000};
    bit          pc_hold = 1'b0;
    localparam logic [1:0] EXP_STALL_HALTED = 2'b01;
`else
    localparam logic [1:0] EXP_STALL_HALTED = 2'b00;
`endif

    logic [1:0]  a_core_reset, a_halted, b_core_reset, b_halted;
    logic        a_running, a_done, a_timeout, b_running, b_done, b_timeout;
    logic [15:0] a_cycle_count, b_cycle_count;

    always #5 clk = ~clk;

    run_ctrl #(.N_CORES(2), .INIT_CYCLES(A_INIT), .RST_CYCLES(A_RST), .MAX_CYCLES(A_MAX),
               .CNT_W(16), .STALL_CYCLES(STALL)) dut_a (
        .clk(clk), .reset(reset), .halt(halt), .restart(restart),
`ifdef RUN_CTRL_PC_STALL_EN
        .pc(pc),
`endif
        .core_reset(a_core_reset), .running(a_running), .done(a_done), .timeout(a_timeout),
        .halted(a_halted), .cycle_count(a_cycle_count)
    );

    run_ctrl #(.N_CORES(2), .INIT_CYCLES(B_INIT), .RST_CYCLES(B_RST), .MAX_CYCLES(B_MAX),
               .CNT_W(16), .STALL_CYCLES(STALL)) dut_b (
        .clk(clk), .reset(reset), .halt(halt), .restart(restart),
`ifdef RUN_CTRL_PC_STALL_EN
        .pc(pc),
`endif
        .core_reset(b_core_reset), .running(b_running), .done(b_done), .timeout(b_timeout),
        .halted(b_halted), .cycle_count(b_cycle_count)
    );

    // Timeline model: m_age counts cycles since the sequence started; WAIT, RST and RUN are
    // windows of that age. A finished run is DONE or TIMEOUT depending on m_to.
    int         m_age [2];
    bit         m_fin [2];
    bit         m_to  [2];
    int         m_cyc [2];
    logic [1:0] m_hl  [2];
    int          m_sc   [2][2];
    logic [31:0] m_prev [2][2];

    function automatic int p_init(input int i); return (i == 0) ? A_INIT : B_INIT; endfunction
    function automatic int p_rst (input int i); return (i == 0) ? A_RST  : B_RST;  endfunction
    function automatic int p_max (input int i); return (i == 0) ? A_MAX  : B_MAX;  endfunction

    function automatic bit m_running(input int i);
        return !m_fin[i] && (m_age[i] >= p_init(i) + p_rst(i));
    endfunction

    function automatic logic [1:0] m_core_reset(input int i);
        return (!m_fin[i] && m_age[i] >= p_init(i) && m_age[i] < p_init(i) + p_rst(i)) ? 2'b11 : 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        logic [1:0] h;
        for (int i = 0; i < 2; i++) begin
            h = halt;
`ifdef RUN_CTRL_PC_STALL_EN
            for (int c = 0; c < 2; c++) begin
                if (reset && m_running(i)) begin
                    if (m_sc[i][c] >= STALL) h[c] = 1'b1;
                    if (pc[32*c +: 32] == m_prev[i][c])
                        m_sc[i][c] = (m_sc[i][c] < STALL) ? m_sc[i][c] + 1 : STALL;
                    else
                        m_sc[i][c] = 0;
                end else begin
                    m_sc[i][c] = 0;
                end
                m_prev[i][c] = pc[32*c +: 32];
            end
`endif
            if (!reset) begin
                m_age[i] = 0; m_fin[i] = 1'b0; m_to[i] = 1'b0; m_cyc[i] = 0; m_hl[i] = 2'b00;
            end else if (m_fin[i]) begin
                if (restart) begin
                    m_age[i] = p_init(i); m_fin[i] = 1'b0; m_to[i] = 1'b0; m_cyc[i] = 0; m_hl[i] = 2'b00;
                end
            end else if (m_running(i)) begin
                m_hl[i]  = m_hl[i] | h;
                m_cyc[i] = m_cyc[i] + 1;
                if (m_hl[i] == 2'b11) begin
                    m_fin[i] = 1'b1; m_to[i] = 1'b0;
                end else if (m_cyc[i] == p_max(i)) begin
                    m_fin[i] = 1'b1; m_to[i] = 1'b1;
                end
            end else begin
                if (m_age[i] >= p_init(i)) begin
                    m_hl[i] = 2'b00; m_cyc[i] = 0;
                end
                m_age[i] = m_age[i] + 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("a_core_reset",  a_core_reset,  m_core_reset(0));
            check("a_running",     a_running,     m_running(0));
            check("a_done",        a_done,        m_fin[0] && !m_to[0]);
            check("a_timeout",     a_timeout,     m_fin[0] && m_to[0]);
            check("a_halted",      a_halted,      m_hl[0]);
            check("a_cycle_count", a_cycle_count, m_cyc[0]);
            check("b_core_reset",  b_core_reset,  m_core_reset(1));
            check("b_running",     b_running,     m_running(1));
            check("b_done",        b_done,        m_fin[1] && !m_to[1]);
            check("b_timeout",     b_timeout,     m_fin[1] && m_to[1]);
            check("b_halted",      b_halted,      m_hl[1]);
            check("b_cycle_count", b_cycle_count, m_cyc[1]);
        end
    end

    task automatic tick();
        @(negedge clk);
`ifdef RUN_CTRL_PC_STALL_EN
        if (!pc_hold) pc[31:0] = pc[31:0] + 32'd4;
        pc[63:32] = pc[63:32] + 32'd4;
`endif
    endtask

    // Advance to the negedge inside RUN cycle k of instance A (cycle_count == k).
    task automatic wait_cycle(input int k);
        int n;
        n = 0;
        while (!(m_running(0) && m_cyc[0] == k) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_cycle: run cycle %0d never reached", k);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        int n;
        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        reset = 1'b1;
        check("b_init0_core_reset", b_core_reset, 2'b11);

        // Default start-up: 50 WAIT cycles, 1 core-reset cycle, then RUN.
        n = 0;
        while (a_core_reset == 2'b00 && n < 200) begin n++; tick(); end
        check("a_wait_len", n, 50);
        n = 0;
        while (a_core_reset == 2'b11 && n < 20) begin n++; tick(); end
        check("a_rst_len", n, 1);
        check("a_running_start", a_running, 1);
        check("a_cc_start", a_cycle_count, 0);

        // Staggered halts: core0 at cycle 10, core1 at cycle 20.
        wait_cycle(10); halt = 2'b01; tick(); halt = 2'b00;
        check("a_halted_c10", a_halted, 2'b01);
        wait_cycle(20); halt = 2'b10; tick(); halt = 2'b00;
        check("a_done_c20", a_done, 1);
        check("a_cc_done_c20", a_cycle_count, 21);
        check("a_running_done", a_running, 0);
        halt = 2'b11; repeat (3) tick(); halt = 2'b00;
        check("a_cc_frozen", a_cycle_count, 21);

        // Restart, then run into the timeout.
        pulse_restart();
        check("a_restart_core_reset", a_core_reset, 2'b11);
        check("a_restart_halted", a_halted, 2'b00);
        check("a_restart_cc", a_cycle_count, 0);
        check("a_restart_done", a_done, 0);
        tick();
        check("a_restart_running", a_running, 1);
        wait_cycle(999); tick();
        check("a_timeout", a_timeout, 1);
        check("a_cc_timeout", a_cycle_count, 1000);

        // All halts on the last budget cycle: DONE wins.
        pulse_restart();
        check("a_restart2_core_reset", a_core_reset, 2'b11);
        check("a_restart2_timeout", a_timeout, 0);
        wait_cycle(999); halt = 2'b11; tick(); halt = 2'b00;
        check("a_done_wins", a_done, 1);
        check("a_no_timeout", a_timeout, 0);
        check("a_cc_done_wins", a_cycle_count, 1000);

        // Reset in the middle of a run.
        pulse_restart();
        wait_cycle(5); halt = 2'b01; tick(); halt = 2'b00;
        wait_cycle(300); reset = 1'b0; tick(); reset = 1'b1;
        check("a_rst_mid_core_reset", a_core_reset, 2'b00);
        check("a_rst_mid_running", a_running, 0);
        check("a_rst_mid_halted", a_halted, 2'b00);
        check("a_rst_mid_cc", a_cycle_count, 0);
        check("b_rst_mid_core_reset", b_core_reset, 2'b11);

        // Immediate halt in the first RUN cycle, then a run with core0's PC parked.
        wait_cycle(0); halt = 2'b11; tick(); halt = 2'b00;
        check("a_cc_first_cycle_done", a_cycle_count, 1);
`ifdef RUN_CTRL_PC_STALL_EN
        pc_hold = 1'b1;
        pc[31:0] = 32'h0000_3010;
`endif
        pulse_restart();
        wait_cycle(10);
        check("a_stall_halted", a_halted, EXP_STALL_HALTED);
        wait_cycle(999); tick();
        check("a_stall_timeout", a_timeout, 1);
`ifdef RUN_CTRL_PC_STALL_EN
        pc_hold = 1'b0;
`endif

        // Randomized halt / restart / reset traffic.
        for (int t = 0; t < 4000; t++) begin
            halt[0] = ($urandom_range(0, 99) == 0);
            halt[1] = ($urandom_range(0, 99) == 0);
            restart = ($urandom_range(0, 9) == 0);
            reset   = ($urandom_range(0, 799) != 0);
            tick();
        end
        halt = 2'b00; restart = 1'b0; reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
